// File: rtl/alu4_pkg.sv
// Shared constants and FSM state type for the nibble-serial ALU.
package alu4_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [1:0] BMODE_NORMAL = 2'b00;
  localparam logic [1:0] BMODE_ONE    = 2'b01;
  localparam logic [1:0] BMODE_CLEAR  = 2'b10;
  localparam logic [1:0] BMODE_LSR    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit add slice with carry-out and signed-overflow flag.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       v
);

  logic [2:0] lo;
  logic       c3;

  always_comb begin
    {c3, lo} = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
    {co, s}  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    v        = c3 ^ co;
  end

endmodule

// File: rtl/alu4_nibble_seq.sv
// Nibble-serial adder: B is conditioned at full width on accept, then one
// 4-bit slice is stepped LSB nibble first, carrying between cycles.
module alu4_nibble_seq
  import alu4_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic [1:0]                  b_mode,
  input  logic                        b_inv,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] s,
  output logic                        c,
  output logic                        zero,
  output logic                        overflow
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned KW = $clog2(NIBBLES);

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    bc_r;
  logic [W-1:0]    res_r;
  logic [W-1:0]    res_full;
  logic [W-1:0]    bm;
  logic [W-1:0]    bc_next;
  logic            carry;
  logic            zacc;
  logic [KW-1:0]   k;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      sn;
  logic            co;
  logic            v;
  logic            last;

  always_comb begin
    bm = '0;
    case (b_mode)
      BMODE_NORMAL: bm = b;
      BMODE_ONE:    bm = {{(W-1){1'b0}}, 1'b1};
      BMODE_CLEAR:  bm = '0;
      BMODE_LSR:    bm = {cin, b[W-1:1]};
      default:      bm = b;
    endcase
    bc_next = b_inv ? ~bm : bm;
  end

  assign a_nib = a_r[{k, 2'b00} +: NIBBLE_W];
  assign b_nib = bc_r[{k, 2'b00} +: NIBBLE_W];
  assign last  = (k == KW'(NIBBLES - 1));

  nibble_add4 u_add (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (sn),
    .co (co),
    .v  (v)
  );

  // Merge the current nibble so the final cycle can publish the whole word.
  always_comb begin
    res_full = res_r;
    res_full[{k, 2'b00} +: NIBBLE_W] = sn;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      s        <= '0;
      c        <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      a_r      <= '0;
      bc_r     <= '0;
      res_r    <= '0;
      carry    <= 1'b0;
      zacc     <= 1'b0;
      k        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            bc_r  <= bc_next;
            carry <= cin;
            k     <= '0;
            zacc  <= 1'b1;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_r <= res_full;
          carry <= co;
          zacc  <= zacc & (sn == '0);
          k     <= k + KW'(1);
          if (last) begin
            s        <= res_full;
            c        <= co;
            zero     <= zacc & (sn == '0);
            overflow <= v;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_nibble_seq.sv
// Scoreboard bench for alu4_nibble_seq with NIBBLES=4 (16-bit operands).
module tb_alu4_nibble_seq;
  import alu4_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         v;
    int unsigned  cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   b_mode;
  logic         b_inv;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c;
  logic         zero;
  logic         overflow;

  exp_t        q[$];
  exp_t        pend;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_done = 0;

  alu4_nibble_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .b_mode   (b_mode),
    .b_inv    (b_inv),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .c        (c),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic [1:0] m, input logic inv, input logic ci);
    exp_t         e;
    logic [W-1:0] bc;
    logic [W:0]   sum;
    case (m)
      BMODE_NORMAL: bc = bb;
      BMODE_ONE:    bc = 16'h0001;
      BMODE_CLEAR:  bc = 16'h0000;
      default:      bc = {ci, bb[W-1:1]};
    endcase
    if (inv) bc = ~bc;
    sum   = {1'b0, aa} + {1'b0, bc} + {16'h0000, ci};
    e.s   = sum[W-1:0];
    e.c   = sum[W];
    e.z   = (sum[W-1:0] == 16'h0000);
    e.v   = (aa[W-1] == bc[W-1]) && (sum[W-1] != aa[W-1]);
    e.cyc = 0;
    return e;
  endfunction

  // Drive an operation with start raised; expected result kept in pend.
  task automatic set_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [1:0] m, input logic inv, input logic ci);
    a      = aa;
    b      = bb;
    b_mode = m;
    b_inv  = inv;
    cin    = ci;
    start  = 1'b1;
    pend   = model(aa, bb, m, inv, ci);
  endtask

  task automatic accepted();
    @(posedge clk);
    #1;
    pend.cyc = cyc + N;
    q.push_back(pend);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    if (q.size() != 0) check("timeout", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      n_done++;
      check("busy_done_excl", {31'd0, busy}, 0);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("latency", cyc, e.cyc);
        check("s", {16'd0, s}, {16'd0, e.s});
        check("c", {31'd0, c}, {31'd0, e.c});
        check("zero", {31'd0, zero}, {31'd0, e.z});
        check("overflow", {31'd0, overflow}, {31'd0, e.v});
      end
    end
  end

  initial begin
    int unsigned saved;
    rst_n = 1'b0; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    b_mode = BMODE_NORMAL; b_inv = 1'b0; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_s", {16'd0, s}, 0);
    check("rst_c", {31'd0, c}, 0);
    check("rst_zero", {31'd0, zero}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;

    // Single operations from the test plan
    set_op(16'h1234, 16'h0FFF, BMODE_NORMAL, 1'b0, 1'b0); accepted(); start = 1'b0; wait_idle();
    set_op(16'h0005, 16'h0005, BMODE_NORMAL, 1'b1, 1'b1); accepted(); start = 1'b0; wait_idle();
    set_op(16'h7FFF, 16'h5555, BMODE_ONE,    1'b0, 1'b0); accepted(); start = 1'b0; wait_idle();
    set_op(16'h0000, 16'h0003, BMODE_LSR,    1'b0, 1'b1); accepted(); start = 1'b0; wait_idle();
    set_op(16'h0001, 16'hABCD, BMODE_CLEAR,  1'b1, 1'b0); accepted(); start = 1'b0; wait_idle();

    // start during RUN must be ignored
    saved = n_done;
    set_op(16'h0100, 16'h0023, BMODE_NORMAL, 1'b0, 1'b0); accepted(); start = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check("run_start_ignored", n_done - saved, 1);

    // Back-to-back with start held through DONE
    saved = n_done;
    set_op(16'hFFFF, 16'h0001, BMODE_NORMAL, 1'b0, 1'b0); accepted();
    set_op(16'h8000, 16'h8000, BMODE_NORMAL, 1'b0, 1'b0); repeat (N) @(posedge clk); accepted();
    set_op(16'h1111, 16'h2222, BMODE_NORMAL, 1'b0, 1'b0); repeat (N) @(posedge clk); accepted();
    start = 1'b0;
    wait_idle();
    check("b2b_done_count", n_done - saved, 3);

    // Abort with reset in the second RUN cycle
    saved = n_done;
    set_op(16'h1234, 16'h0FFF, BMODE_NORMAL, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_s", {16'd0, s}, 0);
    check("abort_c", {31'd0, c}, 0);
    check("abort_zero", {31'd0, zero}, 0);
    check("abort_ovf", {31'd0, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_no_done", n_done - saved, 0);
    set_op(16'h1234, 16'h0FFF, BMODE_NORMAL, 1'b0, 1'b0); accepted(); start = 1'b0; wait_idle();
    check("post_abort_done", n_done - saved, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
